// File: rtl/msk_and_hpc3_cross_pipe.sv
// ---------------------------------------------------------------------------
// msk_and_hpc3_cross_pipe
//
// Purpose:
//    W-bit-wide, d-share masked AND that computes only the HPC3 cross-domain
//    terms, i.e. per bit lane the sharing of XOR over i!=j of a_i & b_j.
//    The same-domain terms a_i & b_i are added by the caller to form the full
//    product. A single register stage sits behind a valid/ready handshake, so
//    the block can stall inside a pipelined datapath without losing results.
//
// Ports:
//    clk        clock, all state updates on the rising edge
//    rst        synchronous reset, active-high
//    in_valid   ina/inb/rnd carry a transfer this cycle
//    in_ready   block can accept a transfer this cycle
//    ina        sharing of a, share i of lane k at bit i*W+k
//    inb        sharing of b, same layout as ina
//    rnd        fresh randomness, lane k uses rnd[k*d*(d-1) +: d*(d-1)],
//               lower half is rnd0, upper half is rnd1
//    out_valid  out holds a result
//    out_ready  consumer takes out this cycle
//    out        cross-term sharing, same layout as ina
// ---------------------------------------------------------------------------
module msk_and_hpc3_cross_pipe #(
   parameter int d = 2,
   parameter int W = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W*d-1:0]         ina,
   input  logic [W*d-1:0]         inb,
   input  logic [W*d*(d-1)-1:0]   rnd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W*d-1:0]         out
);

   localparam int hpc3rnd = d*(d-1);
   localparam int nPairs  = hpc3rnd/2;
   localparam int nSlots  = W*d*(d-1);

   // One u/v register pair per ordered (lane, share i, peer j != i). Slots are
   // packed densely: lane k, share i owns slots (k*d+i)*(d-1) .. +d-2, with
   // peers j<i first and peers j>i shifted down by one to skip the diagonal.
   logic [nSlots-1:0] u_q;
   logic [nSlots-1:0] u_d;
   logic [nSlots-1:0] v_q;
   logic [nSlots-1:0] v_d;
   logic [nSlots-1:0] term;
   logic [W*d-1:0]    aprev_q;
   logic              outValid_q;
   logic              accept;

   assign in_ready  = !outValid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = outValid_q;

   // Per-slot next-state values and registered output terms.
   // The pair (i,j) shares r0/r1 with (j,i), so the r0 and r1 contributions of
   // the two mirrored slots cancel when all output shares are recombined.
   // u and v only ever combine one share with randomness, and the output is
   // built purely from registers, so no input glitch reaches out.
   for (genvar k = 0; k < W; k++) begin : gLane
      for (genvar i = 0; i < d; i++) begin : gShare
         localparam int base = (k*d + i)*(d-1);
         for (genvar j = 0; j < d; j++) begin : gPeer
            if (j != i) begin : gCross
               localparam int lo   = (i < j) ? i : j;
               localparam int hi   = (i < j) ? j : i;
               localparam int pIdx = lo*d - lo*(lo+1)/2 + (hi-1-lo);
               localparam int slot = base + ((j < i) ? j : j-1);
               assign u_d[slot]  = (~ina[i*W+k] & rnd[k*hpc3rnd + pIdx])
                                   ^ rnd[k*hpc3rnd + nPairs + pIdx];
               assign v_d[slot]  = inb[j*W+k] ^ rnd[k*hpc3rnd + pIdx];
               assign term[slot] = u_q[slot] ^ (aprev_q[i*W+k] & v_q[slot]);
            end
         end
         assign out[i*W+k] = ^term[base +: d-1];
      end
   end

   // Masked operand registers: they load only when a transfer is accepted and
   // otherwise hold, which keeps out stable during backpressure. Reset clears
   // them so out reads as all zeros after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         u_q     <= '0;
         v_q     <= '0;
         aprev_q <= '0;
      end else if (accept) begin
         u_q     <= u_d;
         v_q     <= v_d;
         aprev_q <= ina;
      end
   end

   // Output valid flag: an accept always leaves a fresh result behind, even
   // when the previous one leaves in the same cycle; a plain output transfer
   // empties the stage. Reset wins over a simultaneous accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q <= 1'b0;
      end else if (accept) begin
         outValid_q <= 1'b1;
      end else if (out_ready) begin
         outValid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_msk_and_hpc3_cross_pipe.sv
// ---------------------------------------------------------------------------
// tb_msk_and_hpc3_cross_pipe
//
// Purpose:
//    Self-checking bench for msk_and_hpc3_cross_pipe. Three instances cover
//    d=2/W=1 (hand-computed share values), d=3/W=4 (random traffic with
//    random backpressure, stall and reset-mid-stall) and d=4/W=8 (full
//    throughput). A single negedge process compares every instance against
//    an algebraic model of the output shares and of the recombined product.
// ---------------------------------------------------------------------------
module tb_msk_and_hpc3_cross_pipe;

   logic clk = 1'b0;
   logic rst;

   // Instance A: d=2, W=1
   logic        inValidA, inReadyA, outValidA, outReadyA;
   logic [1:0]  inaA, inbA, rndA, outA;
   // Instance B: d=3, W=4
   logic        inValidB, inReadyB, outValidB, outReadyB;
   logic [11:0] inaB, inbB, outB;
   logic [23:0] rndB;
   // Instance C: d=4, W=8
   logic        inValidC, inReadyC, outValidC, outReadyC;
   logic [31:0] inaC, inbC, outC;
   logic [95:0] rndC;

   int assertions = 0;
   int failures   = 0;
   bit checkEn    = 1'b0;

   // Model state per instance: pending result flag, expected shares and the
   // expected recombined cross product.
   bit          expValid [0:2];
   logic [63:0] expOut   [0:2];
   logic [7:0]  expCross [0:2];

   always #5 clk = ~clk;

   msk_and_hpc3_cross_pipe #(.d(2), .W(1)) dutA (
      .clk(clk), .rst(rst), .in_valid(inValidA), .in_ready(inReadyA),
      .ina(inaA), .inb(inbA), .rnd(rndA), .out_valid(outValidA),
      .out_ready(outReadyA), .out(outA));

   msk_and_hpc3_cross_pipe #(.d(3), .W(4)) dutB (
      .clk(clk), .rst(rst), .in_valid(inValidB), .in_ready(inReadyB),
      .ina(inaB), .inb(inbB), .rnd(rndB), .out_valid(outValidB),
      .out_ready(outReadyB), .out(outB));

   msk_and_hpc3_cross_pipe #(.d(4), .W(8)) dutC (
      .clk(clk), .rst(rst), .in_valid(inValidC), .in_ready(inReadyC),
      .ina(inaC), .inb(inbC), .rnd(rndC), .out_valid(outValidC),
      .out_ready(outReadyC), .out(outC));

   task automatic checkEq(input string name, input logic [127:0] got, input logic [127:0] want);
      assertions++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, got, want);
      end
   endtask

   // Each output share simplifies algebraically to
   // out_i = XOR over j!=i of (r0_ij ^ r1_ij ^ a_i&b_j).
   function automatic logic [63:0] modelOut(input int dd, input int ww, input logic [63:0] a,
                                            input logic [63:0] b, input logic [127:0] r);
      logic [63:0] res;
      int hr;
      int np;
      res = '0;
      hr  = dd*(dd-1);
      np  = hr/2;
      for (int k = 0; k < ww; k++) begin
         for (int i = 0; i < dd; i++) begin
            logic acc;
            acc = 1'b0;
            for (int j = 0; j < dd; j++) begin
               if (j != i) begin
                  int lo;
                  int hi;
                  int p;
                  lo  = (i < j) ? i : j;
                  hi  = (i < j) ? j : i;
                  p   = lo*dd - lo*(lo+1)/2 + (hi-1-lo);
                  acc = acc ^ r[k*hr+p] ^ r[k*hr+np+p] ^ (a[i*ww+k] & b[j*ww+k]);
               end
            end
            res[i*ww+k] = acc;
         end
      end
      return res;
   endfunction

   // Unmasked cross product per lane: XOR over i!=j of a_i & b_j.
   function automatic logic [7:0] crossProduct(input int dd, input int ww, input logic [63:0] a,
                                                input logic [63:0] b);
      logic [7:0] res;
      res = '0;
      for (int k = 0; k < ww; k++)
         for (int i = 0; i < dd; i++)
            for (int j = 0; j < dd; j++)
               if (j != i) res[k] = res[k] ^ (a[i*ww+k] & b[j*ww+k]);
      return res;
   endfunction

   function automatic logic [7:0] recombine(input int dd, input int ww, input logic [63:0] o);
      logic [7:0] res;
      res = '0;
      for (int k = 0; k < ww; k++)
         for (int i = 0; i < dd; i++)
            res[k] = res[k] ^ o[i*ww+k];
      return res;
   endfunction

   // Compares one instance against the model for the cycle ahead of the next
   // rising edge, then advances the model across that edge.
   task automatic checkOutput(input int id, input string nm, input int dd, input int ww,
                              input logic rstS, input logic inValid, input logic inReady,
                              input logic outValid, input logic outReady, input logic [63:0] a,
                              input logic [63:0] b, input logic [127:0] r, input logic [63:0] o);
      bit acc;
      bit xfer;
      if (checkEn) begin
         checkEq({nm, ".out_valid"}, 128'(outValid), 128'(expValid[id]));
         checkEq({nm, ".in_ready"}, 128'(inReady), 128'(!expValid[id] || outReady));
         checkEq({nm, ".out"}, 128'(o), 128'(expOut[id]));
         if (expValid[id])
            checkEq({nm, ".recombined"}, 128'(recombine(dd, ww, o)), 128'(expCross[id]));
      end
      if (rstS) begin
         expValid[id] = 1'b0;
         expOut[id]   = '0;
         expCross[id] = '0;
      end else begin
         acc  = inValid && (!expValid[id] || outReady);
         xfer = expValid[id] && outReady;
         if (acc) begin
            expValid[id] = 1'b1;
            expOut[id]   = modelOut(dd, ww, a, b, r);
            expCross[id] = crossProduct(dd, ww, a, b);
         end else if (xfer) begin
            expValid[id] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      checkOutput(0, "A", 2, 1, rst, inValidA, inReadyA, outValidA, outReadyA,
                  64'(inaA), 64'(inbA), 128'(rndA), 64'(outA));
      checkOutput(1, "B", 3, 4, rst, inValidB, inReadyB, outValidB, outReadyB,
                  64'(inaB), 64'(inbB), 128'(rndB), 64'(outB));
      checkOutput(2, "C", 4, 8, rst, inValidC, inReadyC, outValidC, outReadyC,
                  64'(inaC), 64'(inbC), 128'(rndC), 64'(outC));
   end

   // Random producer/consumer on instance B: inputs are held until accepted,
   // out_ready toggles with 50% probability.
   task automatic applyStimulus(input int nAccepts);
      int got    = 0;
      int cycles = 0;
      bit fire   = 1'b0;
      while (cycles < 10000) begin
         @(posedge clk);
         #1;
         cycles++;
         if (fire) got++;
         if (got >= nAccepts) break;
         if (fire || !inValidB) begin
            inValidB = ($urandom_range(0, 3) != 0);
            inaB     = 12'($urandom);
            inbB     = 12'($urandom);
            rndB     = 24'($urandom);
         end
         outReadyB = 1'($urandom_range(0, 1));
         @(negedge clk);
         fire = inValidB && inReadyB;
      end
      checkEq("B.random_accepts", 128'(got), 128'(nAccepts));
      inValidB = 1'b0;
   endtask

   initial begin
      int tpCount;
      rst = 1'b1;
      inValidA = 0; outReadyA = 0; inaA = '0; inbA = '0; rndA = '0;
      inValidB = 0; outReadyB = 0; inaB = '0; inbB = '0; rndB = '0;
      inValidC = 0; outReadyC = 0; inaC = '0; inbC = '0; rndC = '0;
      @(posedge clk);
      #1;
      checkEn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      checkEq("reset.A.out_valid", 128'(outValidA), 128'(0));
      checkEq("reset.B.out_valid", 128'(outValidB), 128'(0));
      checkEq("reset.B.out", 128'(outB), 128'(0));
      checkEq("reset.B.in_ready", 128'(inReadyB), 128'(1));
      checkEq("reset.C.out", 128'(outC), 128'(0));

      // Hand-computed d=2 cases: a0=1, b1=1, so the cross product is 1
      @(posedge clk);
      #1;
      inaA = 2'b01; inbA = 2'b10; rndA = 2'b00; inValidA = 1'b1; outReadyA = 1'b1;
      @(posedge clk);
      #1;
      rndA = 2'b11;
      @(negedge clk);
      checkEq("A.lit_rnd00.valid", 128'(outValidA), 128'(1));
      checkEq("A.lit_rnd00.out", 128'(outA), 128'(2'b01));
      checkEq("A.lit_rnd00.xor", 128'(^outA), 128'(1));
      @(posedge clk);
      #1;
      rndA = 2'b10;
      @(negedge clk);
      checkEq("A.lit_rnd11.out", 128'(outA), 128'(2'b01));
      @(posedge clk);
      #1;
      inValidA = 1'b0;
      @(negedge clk);
      checkEq("A.lit_rnd10.out", 128'(outA), 128'(2'b10));
      checkEq("A.lit_rnd10.xor", 128'(^outA), 128'(1));

      // Random traffic with random backpressure on d=3, W=4
      applyStimulus(1000);
      outReadyB = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: accept, then stall 5 cycles with the next input waiting
      inValidB = 1'b1; inaB = 12'($urandom); inbB = 12'($urandom); rndB = 24'($urandom);
      @(posedge clk);
      #1;
      inaB = 12'($urandom); inbB = 12'($urandom); rndB = 24'($urandom);
      outReadyB = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checkEq("B.stall.in_ready", 128'(inReadyB), 128'(0));
         checkEq("B.stall.out_valid", 128'(outValidB), 128'(1));
         @(posedge clk);
         #1;
      end
      outReadyB = 1'b1;
      @(negedge clk);
      checkEq("B.release.in_ready", 128'(inReadyB), 128'(1));
      @(posedge clk);
      #1;
      inValidB = 1'b0;
      outReadyB = 1'b0;
      @(negedge clk);
      checkEq("B.release.out_valid", 128'(outValidB), 128'(1));

      // Reset while a result is stalled
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkEq("B.rst_stall.out_valid", 128'(outValidB), 128'(0));
      checkEq("B.rst_stall.out", 128'(outB), 128'(0));
      checkEq("B.rst_stall.in_ready", 128'(inReadyB), 128'(1));

      // Full throughput on d=4, W=8: 16 back-to-back accepts
      @(posedge clk);
      #1;
      inValidC = 1'b1; outReadyC = 1'b1;
      inaC = $urandom; inbC = $urandom; rndC = {$urandom, $urandom, $urandom};
      tpCount = 0;
      for (int n = 0; n < 16; n++) begin
         @(posedge clk);
         #1;
         if (n < 15) begin
            inaC = $urandom; inbC = $urandom; rndC = {$urandom, $urandom, $urandom};
         end else begin
            inValidC = 1'b0;
         end
         @(negedge clk);
         if (outValidC) tpCount++;
      end
      checkEq("C.throughput", 128'(tpCount), 128'(16));

      outReadyA = 1'b1; outReadyB = 1'b1; outReadyC = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
